// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: shift-register scoreboard of in-flight writers,
// driving stall, per-operand forward selects, branch flush and stall count.
//
// Ports:
//   clk, reset (async, active-low)
//   i_valid_D, i_rs1, i_rs2, i_use1, i_use2   decode operand reads
//   i_wa_D, i_regwrite_D, i_load_D            decode destination info
//   i_pcsrc                                   taken branch resolved in E
//   o_stall, o_flush                          pipeline control
//   o_fwd1, o_fwd2                            0 = regfile, k = stage k result
//   o_stall_cnt                               saturating stall-cycle count
module hazard_scoreboard #(
  parameter int REG_W      = 4,
  parameter int NSTAGE     = 3,
  parameter int FWD_EN     = 1,
  parameter int LOAD_STAGE = 2,
  parameter int FLUSH_LEN  = 2,
  parameter int CNT_W      = 8,
  localparam int SEL_W     = $clog2(NSTAGE + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid_D,
  input  logic [REG_W-1:0] i_rs1,
  input  logic [REG_W-1:0] i_rs2,
  input  logic             i_use1,
  input  logic             i_use2,
  input  logic [REG_W-1:0] i_wa_D,
  input  logic             i_regwrite_D,
  input  logic             i_load_D,
  input  logic             i_pcsrc,
  output logic             o_stall,
  output logic             o_flush,
  output logic [SEL_W-1:0] o_fwd1,
  output logic [SEL_W-1:0] o_fwd2,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam int FCW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

  logic [NSTAGE:1]  r_v;
  logic [NSTAGE:1]  r_ld;
  logic [REG_W-1:0] r_wa [1:NSTAGE];
  logic [FCW-1:0]   r_fcnt;
  logic [CNT_W-1:0] r_cnt;

  logic             w_hit1;
  logic             w_hit2;
  logic             w_lu1;
  logic             w_lu2;
  logic [SEL_W-1:0] w_sel1;
  logic [SEL_W-1:0] w_sel2;
  logic             w_flush;
  logic             w_stall;

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    w_lu1  = 1'b0;
    w_lu2  = 1'b0;
    w_sel1 = '0;
    w_sel2 = '0;
    for (int k = NSTAGE; k >= 1; k--) begin
      if (i_use1 && i_valid_D && r_v[k] && (r_wa[k] == i_rs1)) begin
        w_hit1 = 1'b1;
        w_lu1  = r_ld[k] && (k < LOAD_STAGE);
        w_sel1 = SEL_W'(k);
      end
      if (i_use2 && i_valid_D && r_v[k] && (r_wa[k] == i_rs2)) begin
        w_hit2 = 1'b1;
        w_lu2  = r_ld[k] && (k < LOAD_STAGE);
        w_sel2 = SEL_W'(k);
      end
    end
  end

  assign w_flush = i_pcsrc | (r_fcnt != '0);
  assign w_stall = (FWD_EN != 0) ? (w_lu1 | w_lu2) : (w_hit1 | w_hit2);

  // Outputs are held low while reset is asserted, independent of inputs.
  assign o_flush     = reset & w_flush;
  assign o_stall     = reset & w_stall & ~w_flush;
  assign o_fwd1      = (reset && FWD_EN != 0) ? w_sel1 : '0;
  assign o_fwd2      = (reset && FWD_EN != 0) ? w_sel2 : '0;
  assign o_stall_cnt = r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v    <= '0;
      r_ld   <= '0;
      r_fcnt <= '0;
      r_cnt  <= '0;
      for (int k = 1; k <= NSTAGE; k++) begin
        r_wa[k] <= '0;
      end
    end else begin
      for (int k = NSTAGE; k >= 2; k--) begin
        r_v[k]  <= r_v[k-1];
        r_ld[k] <= r_ld[k-1];
        r_wa[k] <= r_wa[k-1];
      end
      r_v[1]  <= i_valid_D & i_regwrite_D & ~o_stall & ~o_flush;
      r_ld[1] <= i_load_D;
      r_wa[1] <= i_wa_D;
      if (i_pcsrc) begin
        r_fcnt <= FCW'(FLUSH_LEN - 1);
      end else if (r_fcnt != '0) begin
        r_fcnt <= r_fcnt - 1'b1;
      end
      if (o_stall && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard: a forwarding
// instance (defaults) and a stall-only instance (FWD_EN=0).
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset;

  logic       valid, use1, use2, rw, ld, pcsrc;
  logic [3:0] rs1, rs2, wa;
  logic       stall, flush;
  logic [1:0] fwd1, fwd2;
  logic [7:0] cnt;

  logic       valid_b, use1_b, use2_b, rw_b, ld_b, pcsrc_b;
  logic [3:0] rs1_b, rs2_b, wa_b;
  logic       stall_b, flush_b;
  logic [1:0] fwd1_b, fwd2_b;
  logic [7:0] cnt_b;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset),
    .i_valid_D(valid), .i_rs1(rs1), .i_rs2(rs2),
    .i_use1(use1), .i_use2(use2), .i_wa_D(wa),
    .i_regwrite_D(rw), .i_load_D(ld), .i_pcsrc(pcsrc),
    .o_stall(stall), .o_flush(flush),
    .o_fwd1(fwd1), .o_fwd2(fwd2), .o_stall_cnt(cnt)
  );

  hazard_scoreboard #(.FWD_EN(0)) dut_b (
    .clk(clk), .reset(reset),
    .i_valid_D(valid_b), .i_rs1(rs1_b), .i_rs2(rs2_b),
    .i_use1(use1_b), .i_use2(use2_b), .i_wa_D(wa_b),
    .i_regwrite_D(rw_b), .i_load_D(ld_b), .i_pcsrc(pcsrc_b),
    .o_stall(stall_b), .o_flush(flush_b),
    .o_fwd1(fwd1_b), .o_fwd2(fwd2_b), .o_stall_cnt(cnt_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [3:0] s1,
                       input logic [3:0] s2, input logic u1,
                       input logic u2, input logic [3:0] w,
                       input logic r, input logic l);
    valid = v; rs1 = s1; rs2 = s2; use1 = u1; use2 = u2;
    wa = w; rw = r; ld = l;
  endtask

  task automatic set_b(input logic v, input logic [3:0] s1,
                       input logic u1, input logic [3:0] w,
                       input logic r);
    valid_b = v; rs1_b = s1; rs2_b = 4'd0; use1_b = u1;
    use2_b = 1'b0; wa_b = w; rw_b = r; ld_b = 1'b0;
  endtask

  task automatic drain();
    set_a(0, 0, 0, 0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);
    pcsrc = 1'b0;
    pcsrc_b = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    drain();
    reset = 1'b0;
    #3;
    n_total++;
    if ({stall, flush, fwd1, fwd2, cnt} !== 14'd0) begin
      $display("FAIL reset_outs got=%h exp=0",
               {stall, flush, fwd1, fwd2, cnt});
    end else n_pass++;
    n_total++;
    if ({stall_b, flush_b, cnt_b} !== 10'd0) begin
      $display("FAIL reset_outs_b got=%h exp=0", {stall_b, flush_b, cnt_b});
    end else n_pass++;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_fwd_chain();
    int exp_f[4] = '{1, 2, 3, 0};
    set_a(1, 0, 0, 0, 0, 3, 1, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      set_a(1, 3, 0, 1, 0, 0, 0, 0);
      #2;
      n_total++;
      if (fwd1 !== 2'(exp_f[i])) begin
        $display("FAIL fwd_chain_%0d fwd1 got=%0d exp=%0d", i, fwd1, exp_f[i]);
      end else n_pass++;
      n_total++;
      if (stall !== 1'b0) begin
        $display("FAIL fwd_chain_stall_%0d got=%b exp=0", i, stall);
      end else n_pass++;
      tick();
    end
    drain();
  endtask

  task automatic test_load_use();
    set_a(1, 0, 0, 0, 0, 5, 1, 1);
    tick();
    set_a(1, 0, 5, 0, 1, 0, 0, 0);
    #2;
    n_total++;
    if (stall !== 1'b1) begin
      $display("FAIL load_use_stall got=%b exp=1", stall);
    end else n_pass++;
    tick();
    #2;
    n_total++;
    if ({stall, fwd2} !== {1'b0, 2'd2}) begin
      $display("FAIL load_use_fwd stall=%b fwd2=%0d exp stall=0 fwd2=2",
               stall, fwd2);
    end else n_pass++;
    n_total++;
    if (cnt !== 8'd1) begin
      $display("FAIL load_use_cnt got=%0d exp=1", cnt);
    end else n_pass++;
    tick();
    drain();
  endtask

  task automatic test_youngest();
    set_a(1, 0, 0, 0, 0, 4, 1, 0);
    tick();
    set_a(1, 0, 0, 0, 0, 4, 1, 0);
    tick();
    set_a(1, 4, 4, 1, 1, 0, 0, 0);
    #2;
    n_total++;
    if ({fwd1, fwd2, stall} !== {2'd1, 2'd1, 1'b0}) begin
      $display("FAIL youngest fwd1=%0d fwd2=%0d stall=%b exp 1 1 0",
               fwd1, fwd2, stall);
    end else n_pass++;
    tick();
    drain();
  endtask

  task automatic test_stall_only();
    logic exp_s[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    set_b(1, 0, 0, 2, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      set_b(1, 2, 1, 0, 0);
      #2;
      n_total++;
      if ({stall_b, fwd1_b} !== {exp_s[i], 2'd0}) begin
        $display("FAIL stall_only_%0d stall=%b fwd1=%0d exp stall=%b fwd1=0",
                 i, stall_b, fwd1_b, exp_s[i]);
      end else n_pass++;
      if (i == 3) begin
        n_total++;
        if (cnt_b !== 8'd3) begin
          $display("FAIL stall_only_cnt got=%0d exp=3", cnt_b);
        end else n_pass++;
      end
      tick();
    end
    drain();
  endtask

  task automatic test_flush();
    set_a(1, 0, 0, 0, 0, 6, 1, 1);
    tick();
    set_a(1, 6, 0, 1, 0, 0, 0, 0);
    pcsrc = 1'b1;
    #2;
    n_total++;
    if ({flush, stall} !== 2'b10) begin
      $display("FAIL flush_c0 flush=%b stall=%b exp 1 0", flush, stall);
    end else n_pass++;
    tick();
    pcsrc = 1'b0;
    #2;
    n_total++;
    if ({flush, stall} !== 2'b10) begin
      $display("FAIL flush_c1 flush=%b stall=%b exp 1 0", flush, stall);
    end else n_pass++;
    tick();
    #2;
    n_total++;
    if ({flush, stall, fwd1} !== {1'b0, 1'b0, 2'd3}) begin
      $display("FAIL flush_c2 flush=%b stall=%b fwd1=%0d exp 0 0 3",
               flush, stall, fwd1);
    end else n_pass++;
    n_total++;
    if (cnt !== 8'd1) begin
      $display("FAIL flush_cnt got=%0d exp=1", cnt);
    end else n_pass++;
    tick();
    drain();
    pcsrc = 1'b1;
    #2;
    n_total++;
    if (flush !== 1'b1) $display("FAIL ext_c0 got=%b exp=1", flush);
    else n_pass++;
    tick();
    #2;
    n_total++;
    if (flush !== 1'b1) $display("FAIL ext_c1 got=%b exp=1", flush);
    else n_pass++;
    tick();
    pcsrc = 1'b0;
    #2;
    n_total++;
    if (flush !== 1'b1) $display("FAIL ext_c2 got=%b exp=1", flush);
    else n_pass++;
    tick();
    #2;
    n_total++;
    if (flush !== 1'b0) $display("FAIL ext_c3 got=%b exp=0", flush);
    else n_pass++;
    tick();
    drain();
  endtask

  task automatic test_saturation();
    logic seen;
    seen = 1'b0;
    set_a(1, 7, 0, 1, 0, 7, 1, 1);
    repeat (600) tick();
    #2;
    n_total++;
    if (cnt !== 8'd255) $display("FAIL sat_cnt got=%0d exp=255", cnt);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      if (stall === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
      #2;
    end
    n_total++;
    if (seen !== 1'b1) $display("FAIL sat_stall_seen got=%b exp=1", seen);
    else n_pass++;
    tick();
    #2;
    n_total++;
    if (cnt !== 8'd255) $display("FAIL sat_hold got=%0d exp=255", cnt);
    else n_pass++;
    tick();
    drain();
  endtask

  task automatic test_reset_mid();
    set_a(1, 0, 0, 0, 0, 8, 1, 1);
    tick();
    set_a(1, 8, 0, 1, 0, 0, 0, 0);
    #2;
    n_total++;
    if ({stall, fwd1} !== {1'b1, 2'd1}) begin
      $display("FAIL rmid_pre stall=%b fwd1=%0d exp 1 1", stall, fwd1);
    end else n_pass++;
    pcsrc = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    n_total++;
    if ({stall, flush, fwd1, fwd2, cnt} !== 14'd0) begin
      $display("FAIL rmid_outs got=%h exp=0", {stall, flush, fwd1, fwd2, cnt});
    end else n_pass++;
    tick();
    pcsrc = 1'b0;
    reset = 1'b1;
    set_a(1, 8, 8, 1, 1, 0, 0, 0);
    #2;
    n_total++;
    if ({stall, flush, fwd1, fwd2} !== 6'd0) begin
      $display("FAIL rmid_post stall=%b flush=%b fwd1=%0d fwd2=%0d exp 0",
               stall, flush, fwd1, fwd2);
    end else n_pass++;
    tick();
    drain();
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_fwd_chain();
    test_load_use();
    test_youngest();
    test_stall_only();
    test_flush();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
